// File: rtl/simple_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_cpu_pkg
// Purpose  : Shared opcodes, step encoding, field widths and opcode
//            classification helpers for the simple CPU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package simple_cpu_pkg;

    localparam int FUNC_W = 4;
    localparam int OPER_W = 12;
    localparam int IW     = FUNC_W + OPER_W;

    localparam logic [FUNC_W-1:0] OP_MV  = 4'h0;
    localparam logic [FUNC_W-1:0] OP_MVI = 4'h1;
    localparam logic [FUNC_W-1:0] OP_MVR = 4'h2;
    localparam logic [FUNC_W-1:0] OP_ADD = 4'h3;
    localparam logic [FUNC_W-1:0] OP_XOR = 4'h4;
    localparam logic [FUNC_W-1:0] OP_NOP = 4'hF;

    // Step code seen by the datapath; the value doubles as the FSM state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_S3   = 2'd3
    } step_t;

    // ADD and XOR need the A_in / G_in / G_out sequence over three steps.
    function automatic logic is_multi_step(input logic [FUNC_W-1:0] func);
        return (func == OP_ADD) || (func == OP_XOR);
    endfunction

    // 0x5..0xE are not decoded; they run as a one-step no-op.
    function automatic logic is_illegal_op(input logic [FUNC_W-1:0] func);
        return (func > OP_XOR) && (func < OP_NOP);
    endfunction

endpackage : simple_cpu_pkg
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Purpose  : Instruction-stream handshake plus decoder-facing outputs of the
//            instruction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int FUNC_W = 4,
    parameter int OPER_W = 12,
    parameter int IW     = FUNC_W + OPER_W
);
    logic                 instr_valid;
    logic [IW-1:0]        instr_data;
    logic                 instr_ready;
    logic [FUNC_W-1:0]    func_instruction;
    logic [OPER_W-1:0]    instruction_F;
    simple_cpu_pkg::step_t step;
    logic                 busy;
    logic                 done;
    logic                 illegal;

    // Instruction source / observer side.
    modport master (
        output instr_valid, instr_data,
        input  instr_ready, func_instruction, instruction_F, step, busy, done, illegal
    );

    // Sequencer side.
    modport slave (
        input  instr_valid, instr_data,
        output instr_ready, func_instruction, instruction_F, step, busy, done, illegal
    );
endinterface : instr_sequencer_if
`default_nettype wire

// File: rtl/instr_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo2
// Purpose  : Two-entry synchronous FIFO buffering instruction words ahead of
//            the instruction register.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fifo2 #(
    parameter int IW = 16
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          push,
    input  wire logic [IW-1:0] push_data,
    input  wire logic          pop,
    output logic      [IW-1:0] head,
    output logic      [1:0]    count
);
    logic [IW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    // Overflow / underflow requests are dropped so the pointers never skew.
    assign w_push = push && (r_count != 2'd2);
    assign w_pop  = pop  && (r_count != 2'd0);

    // Pointers and occupancy; reset flushes the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : instr_fifo2
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Multi-cycle instruction sequencer: buffers words in a 2-deep
//            FIFO, latches one into the IR and steps it through 1 or 3
//            execution steps for the control decoder.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int FUNC_W = 4,
    parameter int OPER_W = 12,
    parameter int IW     = FUNC_W + OPER_W
) (
    input wire logic         clk,
    input wire logic         resetn,
    instr_sequencer_if.slave bus
);
    import simple_cpu_pkg::*;

    localparam logic [IW-1:0] c_ir_reset = {OP_NOP, {OPER_W{1'b0}}};

    step_t             r_state;
    logic [IW-1:0]     r_ir;
    logic [FUNC_W-1:0] r_func;

    logic [IW-1:0]     w_head;
    logic [1:0]        w_count;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_final;
    logic [FUNC_W-1:0] w_ir_func;
    logic [FUNC_W-1:0] w_head_func;

    assign w_ir_func   = r_ir[IW-1 -: FUNC_W];
    assign w_head_func = w_head[IW-1 -: FUNC_W];

    // Ready comes from the registered count only: a full FIFO refuses a word
    // even when it is popped in the same cycle.
    assign w_ready = (w_count != 2'd2);
    assign w_push  = bus.instr_valid && w_ready;

    // Last step of the current instruction: S1 of a one-step op, or S3.
    assign w_final = ((r_state == ST_S1) && !is_multi_step(w_ir_func)) ||
                     (r_state == ST_S3);

    // Fetch the next word when idle or finishing, so there is no bubble.
    assign w_pop = ((r_state == ST_IDLE) || w_final) && (w_count != 2'd0);

    instr_fifo2 #(
        .IW (IW)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_push),
        .push_data (bus.instr_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    // Step FSM with IR load; the decoder-facing opcode is registered with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_ir    <= c_ir_reset;
            r_func  <= OP_NOP;
        end else if (w_pop) begin
            r_state <= ST_S1;
            r_ir    <= w_head;
            r_func  <= is_illegal_op(w_head_func) ? OP_NOP : w_head_func;
        end else if ((r_state == ST_IDLE) || w_final) begin
            // Nothing queued: park with the NOP word so the decoder idles.
            r_state <= ST_IDLE;
            r_ir    <= c_ir_reset;
            r_func  <= OP_NOP;
        end else if (r_state == ST_S1) begin
            r_state <= ST_S2;
        end else begin
            r_state <= ST_S3;
        end
    end

    assign bus.instr_ready      = w_ready;
    assign bus.func_instruction = r_func;
    assign bus.instruction_F    = r_ir[OPER_W-1:0];
    assign bus.step             = r_state;
    assign bus.busy             = (r_state != ST_IDLE);
    assign bus.done             = w_final;
    assign bus.illegal          = (r_state == ST_S1) && is_illegal_op(w_ir_func);

endmodule : instr_sequencer
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer: vector table, directed
//            multi-cycle sequences and random traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
    import simple_cpu_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic chk_en = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.FUNC_W(4), .OPER_W(12), .IW(16)) bus();

    instr_sequencer #(
        .FUNC_W (4),
        .OPER_W (12),
        .IW     (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of waiting words plus the instruction in
    // flight and how many of its steps have been executed.
    // ------------------------------------------------------------------
    logic [15:0] m_q[$];
    logic        m_cur_valid = 1'b0;
    logic [15:0] m_cur       = 16'hF000;
    int          m_cur_step  = 0;
    logic        m_acc;

    function automatic int ref_len(input logic [15:0] w);
        return (w[15:12] == 4'h3 || w[15:12] == 4'h4) ? 3 : 1;
    endfunction

    function automatic logic ref_illegal(input logic [15:0] w);
        return (w[15:12] >= 4'h5) && (w[15:12] <= 4'hE);
    endfunction

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_q.delete();
            m_cur_valid = 1'b0;
            m_cur       = 16'hF000;
            m_cur_step  = 0;
        end else begin
            m_acc = bus.instr_valid && (m_q.size() < 2);
            if (!m_cur_valid || m_cur_step == ref_len(m_cur)) begin
                if (m_q.size() > 0) begin
                    m_cur       = m_q.pop_front();
                    m_cur_valid = 1'b1;
                    m_cur_step  = 1;
                end else begin
                    m_cur_valid = 1'b0;
                    m_cur_step  = 0;
                end
            end else begin
                m_cur_step = m_cur_step + 1;
            end
            if (m_acc) m_q.push_back(bus.instr_data);
        end
    end

    task automatic expect_eq(input string name, input logic [15:0] act, input logic [15:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every falling edge compare all outputs with the model's view.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            expect_eq("model_step",  16'(bus.step), m_cur_valid ? 16'(m_cur_step) : 16'd0);
            expect_eq("model_func",  16'(bus.func_instruction),
                      !m_cur_valid ? 16'hF : (ref_illegal(m_cur) ? 16'hF : 16'(m_cur[15:12])));
            expect_eq("model_oper",  16'(bus.instruction_F), m_cur_valid ? 16'(m_cur[11:0]) : 16'd0);
            expect_eq("model_done",  16'(bus.done),
                      16'(m_cur_valid && (m_cur_step == ref_len(m_cur))));
            expect_eq("model_illeg", 16'(bus.illegal), 16'(m_cur_valid && ref_illegal(m_cur)));
            expect_eq("model_busy",  16'(bus.busy), 16'(m_cur_valid));
            expect_eq("model_ready", 16'(bus.instr_ready), 16'(m_q.size() < 2));
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        bus.instr_valid = 1'b1;
        bus.instr_data  = w;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic expect_reset_outputs(input string tag);
        expect_eq({tag, "_func"},  16'(bus.func_instruction), 16'hF);
        expect_eq({tag, "_oper"},  16'(bus.instruction_F), 16'h000);
        expect_eq({tag, "_step"},  16'(bus.step), 16'd0);
        expect_eq({tag, "_busy"},  16'(bus.busy), 16'd0);
        expect_eq({tag, "_done"},  16'(bus.done), 16'd0);
        expect_eq({tag, "_illeg"}, 16'(bus.illegal), 16'd0);
        expect_eq({tag, "_ready"}, 16'(bus.instr_ready), 16'd1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            if (!bus.busy && m_q.size() == 0 && !m_cur_valid) break;
            tick();
        end
        n_assert++;
        if (k == 50) begin
            n_fail++;
            $display("FAIL wait_idle: sequencer still busy after 50 cycles");
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [3:0]  func;
        int          len;
        logic        ill;
    } vec_t;

    vec_t tv[9];
    int   bb_step[6] = '{1, 1, 2, 3, 1, 0};
    int   bb_done[6] = '{1, 0, 0, 1, 1, 0};
    logic [15:0] bb_word[3] = '{16'h1045, 16'h4067, 16'h0089};

    initial begin
        tv[0] = '{16'h3012, 4'h3, 3, 1'b0};
        tv[1] = '{16'h1045, 4'h1, 1, 1'b0};
        tv[2] = '{16'h0089, 4'h0, 1, 1'b0};
        tv[3] = '{16'h2ABC, 4'h2, 1, 1'b0};
        tv[4] = '{16'h4067, 4'h4, 3, 1'b0};
        tv[5] = '{16'h9ABC, 4'hF, 1, 1'b1};
        tv[6] = '{16'h5001, 4'hF, 1, 1'b1};
        tv[7] = '{16'hE123, 4'hF, 1, 1'b1};
        tv[8] = '{16'hF777, 4'hF, 1, 1'b0};

        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'h0000;
        resetn          = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk_en = 1'b1;
        expect_reset_outputs("reset_release");

        // Asynchronous reset asserted mid-cycle while an ADD is in S1.
        push_word(16'h3012);
        tick();
        expect_eq("pre_reset_step", 16'(bus.step), 16'd1);
        #2 resetn = 1'b0;
        #1 expect_reset_outputs("reset_async");
        tick();
        tick();
        resetn = 1'b1;
        tick();
        expect_eq("post_reset_step", 16'(bus.step), 16'd0);

        // Vector table: one word into an idle sequencer, step by step.
        for (int i = 0; i < 9; i++) begin
            wait_idle();
            push_word(tv[i].word);
            expect_eq($sformatf("vec%0d_latency", i), 16'(bus.step), 16'd0);
            for (int s = 1; s <= tv[i].len; s++) begin
                tick();
                expect_eq($sformatf("vec%0d_s%0d_step", i, s), 16'(bus.step), 16'(s));
                expect_eq($sformatf("vec%0d_s%0d_func", i, s), 16'(bus.func_instruction), 16'(tv[i].func));
                expect_eq($sformatf("vec%0d_s%0d_oper", i, s), 16'(bus.instruction_F), 16'(tv[i].word[11:0]));
                expect_eq($sformatf("vec%0d_s%0d_done", i, s), 16'(bus.done), 16'(s == tv[i].len));
                expect_eq($sformatf("vec%0d_s%0d_illeg", i, s), 16'(bus.illegal), 16'(tv[i].ill));
                expect_eq($sformatf("vec%0d_s%0d_busy", i, s), 16'(bus.busy), 16'd1);
            end
            tick();
            expect_eq($sformatf("vec%0d_end_step", i), 16'(bus.step), 16'd0);
            expect_eq($sformatf("vec%0d_end_func", i), 16'(bus.func_instruction), 16'hF);
            expect_eq($sformatf("vec%0d_end_oper", i), 16'(bus.instruction_F), 16'h000);
        end

        // Back-to-back: MVI, XOR, MV pushed on consecutive cycles.
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr_data  = bb_word[0];
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c < 2) bus.instr_data = bb_word[c+1];
            else       bus.instr_valid = 1'b0;
            if (c >= 1) begin
                expect_eq($sformatf("b2b_c%0d_step", c), 16'(bus.step), 16'(bb_step[c-1]));
                expect_eq($sformatf("b2b_c%0d_done", c), 16'(bus.done), 16'(bb_done[c-1]));
            end
        end

        // Full FIFO: three words offered during an ADD's S1.
        wait_idle();
        push_word(16'h3111);
        tick();
        expect_eq("ff_s1_step", 16'(bus.step), 16'd1);
        bus.instr_valid = 1'b1;
        bus.instr_data  = 16'h1AAA;
        tick();
        expect_eq("ff_ready_1", 16'(bus.instr_ready), 16'd1);
        bus.instr_data = 16'h2BBB;
        tick();
        expect_eq("ff_ready_full", 16'(bus.instr_ready), 16'd0);
        expect_eq("ff_s3_step", 16'(bus.step), 16'd3);
        bus.instr_data = 16'h0CCC;
        tick();
        expect_eq("ff_ready_after_pop", 16'(bus.instr_ready), 16'd1);
        expect_eq("ff_w1_oper", 16'(bus.instruction_F), 16'hAAA);
        tick();
        bus.instr_valid = 1'b0;
        expect_eq("ff_w2_oper", 16'(bus.instruction_F), 16'hBBB);
        expect_eq("ff_w2_func", 16'(bus.func_instruction), 16'h2);
        tick();
        expect_eq("ff_w3_oper", 16'(bus.instruction_F), 16'hCCC);
        expect_eq("ff_w3_done", 16'(bus.done), 16'd1);
        tick();
        expect_eq("ff_end_step", 16'(bus.step), 16'd0);

        // Reset during XOR S2 with one word queued.
        wait_idle();
        push_word(16'h4055);
        bus.instr_valid = 1'b1;
        bus.instr_data  = 16'h1066;
        tick();
        bus.instr_valid = 1'b0;
        expect_eq("rx_s1_step", 16'(bus.step), 16'd1);
        tick();
        expect_eq("rx_s2_step", 16'(bus.step), 16'd2);
        #2 resetn = 1'b0;
        #1 expect_reset_outputs("rx_async");
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_eq($sformatf("rx_idle%0d_step", c), 16'(bus.step), 16'd0);
            expect_eq($sformatf("rx_idle%0d_done", c), 16'(bus.done), 16'd0);
        end
        push_word(16'h2321);
        tick();
        expect_eq("rx_new_step", 16'(bus.step), 16'd1);
        expect_eq("rx_new_oper", 16'(bus.instruction_F), 16'h321);

        // Random traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] rw;
            rw = 16'($urandom());
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr_data  = rw;
            if ($urandom_range(0, 499) == 0) begin
                resetn = 1'b0;
                tick();
                resetn = 1'b1;
            end
            tick();
        end
        bus.instr_valid = 1'b0;
        wait_idle();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_instr_sequencer
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the simple CPU. It buffers incoming 16-bit instruction words in a 2-entry FIFO and latches one at a time into an instruction register. It then steps through 1 or 3 execution steps per instruction. It drives `func_instruction` and `instruction_F` straight into the combinational control decoder, plus a `step` code the datapath uses to qualify the decoder's `A_in`, `G_in` and `G_out` strobes.

## Interface
- `FUNC_W`, default 4: opcode field width.
- `OPER_W`, default 12: operand field width; `[7:4]` = Rx, `[3:0]` = Ry.
- `IW`, default 16: instruction word width, equal to `FUNC_W + OPER_W`.
- `clk`, in, 1: single clock, rising edge.
- `resetn`, in, 1: asynchronous active-low reset.
- `instr_valid`, in, 1: upstream presents a word on `instr_data`.
- `instr_data`, in, `IW`: `[15:12]` is func, `[11:0]` is the operand field.
- `instr_ready`, out, 1: FIFO can accept a word.
- `func_instruction`, out, `FUNC_W`: opcode sent to the decoder.
- `instruction_F`, out, `OPER_W`: operand field sent to the decoder.
- `step`, out, 2: 0 = idle, 1 = S1, 2 = S2, 3 = S3.
- `busy`, out, 1: an instruction is executing (`step != 0`).
- `done`, out, 1: high during the final step of each instruction.
- `illegal`, out, 1: high during the single step of an unsupported opcode.

## Operation
- **FIFO handshake**
  - A word is accepted when `instr_valid && instr_ready` at a rising edge.
  - `instr_ready = (count < 2)`, computed from the registered count only. A full FIFO does not accept, even if it pops in the same cycle.
  - A push and a pop in the same cycle are legal when `count == 1`; the count stays at 1.
- **FSM states:** IDLE, S1, S2, S3. The instruction register (IR) loads from the FIFO head.
  - IDLE with FIFO non-empty: pop, load IR, go to S1.
  - S1 with opcode 0x0, 0x1, 0x2 or unsupported: this is the final step, so `done = 1`.
  - S1 with opcode 0x3 (ADD) or 0x4 (XOR): go to S2, then S3. S3 is the final step and asserts `done`.
  - At any final step: if the FIFO is non-empty, pop and load IR, then go to S1 on the next cycle (no idle bubble). Otherwise go to IDLE.
- **Opcodes 0x5 to 0xE:** execute as a one-step no-op. `func_instruction` is forced to 0xF (NOP, which hits the decoder default), and `illegal = 1` in that S1 cycle.
- **Output drive**
  - `func_instruction`, `instruction_F` and `step` are registered and hold constant for every step of an instruction.
  - In IDLE the outputs are: `func_instruction = 0xF`, `instruction_F = 0`, `step = 0`.
  - `done`, `illegal` and `busy` are decoded from the registered state and IR, with no combinational path from `instr_data`.
- **Reset values:** state IDLE, FIFO empty, IR = `{0xF, 12'h000}`.
  - Resulting outputs: `func_instruction = 0xF`, `instruction_F = 0`, `step = 0`, `busy = 0`, `done = 0`, `illegal = 0`, `instr_ready = 1`.
- **Reset mid-operation:** aborts immediately and flushes the FIFO. No `done` is generated for the aborted instruction.

## Timing
- **Latency:** a word accepted at edge k into an idle, empty sequencer is in S1 for the cycle after edge k+1. That is 2 edges from acceptance to first step.
- **Instruction length:** MV/MVI/0x2/illegal take 1 cycle; ADD/XOR take 3 cycles.
- **Throughput:** with the FIFO kept non-empty, `busy` stays high continuously with no gaps between instructions.
- **`done` pulses:** `done` is high for exactly 1 cycle per instruction. Consecutive one-step instructions give `done` high on consecutive cycles.
- **Empty FIFO at a final step:** the next cycle is IDLE with `step = 0`.

## Structure
- **Package `simple_cpu_pkg`** holds:
  - Opcode constants: `OP_MV = 4'h0`, `OP_MVI = 4'h1`, `OP_MVR = 4'h2`, `OP_ADD = 4'h3`, `OP_XOR = 4'h4`, `OP_NOP = 4'hF`.
  - The step enum: `ST_IDLE`, `ST_S1`, `ST_S2`, `ST_S3` = 0..3.
  - `FUNC_W`, `OPER_W` and `IW`.
- **Sub-module `instr_fifo2`:** 2-entry, `IW`-wide synchronous FIFO with `push`, `pop`, `head`, `count`. `instr_sequencer` contains the FSM and IR.

## Test plan
- **Reset:** assert `resetn = 0` mid-cycle.
  - Required: all outputs at reset values asynchronously, and `instr_ready = 1`.
- **Single ADD:** push 0x3012 while idle.
  - Required: `step` reads 1, 2, 3 on consecutive cycles starting 2 edges after accept.
  - Required: `func_instruction = 3` and `instruction_F = 0x012` throughout; `done` only at `step = 3`; then `step = 0`.
- **Back-to-back:** push 0x1045, 0x4067 and 0x0089 on consecutive cycles.
  - Required: steps 1 | 1, 2, 3 | 1 with no idle cycle between them.
  - Required: `done` pulses at cycles 1, 4 and 5 of execution.
- **Full FIFO:** during an ADD's S1, hold `instr_valid` with 3 distinct words.
  - Required: `instr_ready` drops after 2 accepts.
  - Required: the third word is accepted only after the next pop, and none is lost or duplicated.
- **Illegal opcode:** push 0x9ABC.
  - Required: one step with `func_instruction = 0xF`, `instruction_F = 0xABC`, `illegal = 1`, `done = 1`.
- **Reset mid-XOR:** assert reset during S2 with 1 word queued.
  - Required: no `done`, FIFO flushed, and after release the sequencer stays idle until a new push.
